// File: rtl/alu_decoder_if.sv
// alu_decoder_if -- bundle of the decoder's input handshake, flush and
// decoded-output handshake.
//   instr/in_valid/in_ready : upstream instruction handshake
//   flush                   : discard the held decoded instruction
//   out_valid/out_ready     : downstream ALU-stage handshake
//   alu_op, alu_op_ext, rs1, rs2, rd, imm, use_imm, reg_we : decoded fields
//   illegal                 : present only when ALU_ILLEGAL_TRAP_EN is defined
// Modports: master = the side that feeds instructions and consumes fields,
//           slave  = the decoder itself.
interface alu_decoder_if;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [6:0]  alu_op_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic        illegal;

    modport master (
        output instr, in_valid, flush, out_ready,
        input  in_ready, out_valid, alu_op, alu_op_ext, rs1, rs2, rd,
               imm, use_imm, reg_we, illegal
    );
    modport slave (
        input  instr, in_valid, flush, out_ready,
        output in_ready, out_valid, alu_op, alu_op_ext, rs1, rs2, rd,
               imm, use_imm, reg_we, illegal
    );
`else
    modport master (
        output instr, in_valid, flush, out_ready,
        input  in_ready, out_valid, alu_op, alu_op_ext, rs1, rs2, rd,
               imm, use_imm, reg_we
    );
    modport slave (
        input  instr, in_valid, flush, out_ready,
        output in_ready, out_valid, alu_op, alu_op_ext, rs1, rs2, rd,
               imm, use_imm, reg_we
    );
`endif
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder -- single registered stage that decodes RV32I OP, OP-IMM and
// LUI instructions into ALU control fields, with a valid/ready handshake on
// both sides and a flush that drops the held result.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_decoder_if.slave (instruction in, decoded fields out)
// Configuration macro ALU_ILLEGAL_TRAP_EN:
//   defined   -> illegal instructions are flagged on bus.illegal
//   undefined -> illegal instructions are emitted as a NOP (no illegal port)
module alu_decoder (
    input logic          clk,
    input logic          rst,
    alu_decoder_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic        take;
    logic [2:0]  d_alu_op;
    logic [6:0]  d_alu_op_ext;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_imm;
    logic        d_use_imm;
    logic        d_reg_we;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic        d_illegal;
`endif

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    // The stage can accept whenever its register is empty or being drained;
    // a flush cycle never accepts so the flushed slot stays empty.
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.flush;
    assign take         = bus.in_valid && bus.in_ready;

    // Combinational decode of the incoming word. Fields are computed first,
    // then replaced wholesale by the trap or NOP pattern if the encoding
    // turned out to be illegal.
    always_comb begin
        legal        = 1'b0;
        d_alu_op     = funct3;
        d_alu_op_ext = 7'b0;
        d_rs1        = bus.instr[19:15];
        d_rs2        = bus.instr[24:20];
        d_rd         = bus.instr[11:7];
        d_imm        = 32'b0;
        d_use_imm    = 1'b0;
        d_reg_we     = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
        d_illegal    = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                legal        = (funct7 == F7_BASE) ||
                               ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                d_alu_op_ext = funct7;
                d_reg_we     = 1'b1;
            end
            OPC_OP_IMM: begin
                d_rs2     = 5'b0;
                d_use_imm = 1'b1;
                d_reg_we  = 1'b1;
                case (funct3)
                    3'b001: begin
                        legal = (funct7 == F7_BASE);
                        d_imm = {27'b0, bus.instr[24:20]};
                    end
                    // Only the right shifts carry funct7 through, so ADDI
                    // with a negative immediate can never look like SUB.
                    3'b101: begin
                        legal        = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        d_imm        = {27'b0, bus.instr[24:20]};
                        d_alu_op_ext = funct7;
                    end
                    default: begin
                        legal = 1'b1;
                        d_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
                    end
                endcase
            end
            OPC_LUI: begin
                legal     = 1'b1;
                d_alu_op  = 3'b000;
                d_rs1     = 5'b0;
                d_rs2     = 5'b0;
                d_imm     = {bus.instr[31:12], 12'b0};
                d_use_imm = 1'b1;
                d_reg_we  = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d_alu_op     = 3'b000;
            d_alu_op_ext = 7'b0;
            d_rs1        = 5'b0;
            d_rs2        = 5'b0;
            d_rd         = 5'b0;
            d_imm        = 32'b0;
            d_reg_we     = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
            d_use_imm    = 1'b0;
            d_illegal    = 1'b1;
`else
            d_use_imm    = 1'b1;
`endif
        end
    end

    // Output register. Reset beats flush, flush beats load and hold; the
    // fields only change on a load, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.alu_op     <= 3'b0;
            bus.alu_op_ext <= 7'b0;
            bus.rs1        <= 5'b0;
            bus.rs2        <= 5'b0;
            bus.rd         <= 5'b0;
            bus.imm        <= 32'b0;
            bus.use_imm    <= 1'b0;
            bus.reg_we     <= 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
            bus.illegal    <= 1'b0;
`endif
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (take) begin
            bus.out_valid  <= 1'b1;
            bus.alu_op     <= d_alu_op;
            bus.alu_op_ext <= d_alu_op_ext;
            bus.rs1        <= d_rs1;
            bus.rs2        <= d_rs2;
            bus.rd         <= d_rd;
            bus.imm        <= d_imm;
            bus.use_imm    <= d_use_imm;
            bus.reg_we     <= d_reg_we;
`ifdef ALU_ILLEGAL_TRAP_EN
            bus.illegal    <= d_illegal;
`endif
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
